// File: rtl/rrat_nway.sv
// Retirement RAT: committed arch->phys map with N_WAY in-order commits per cycle.
// Optional superseded-PRN release outputs are built only with RRAT_FREE_OUT_EN.
module rrat_nway #(
    parameter int N_WAY     = 3,
    parameter int ARF_SIZE  = 32,
    parameter int PRF_SIZE  = 64,
    parameter int ZERO_REG  = 31,
    parameter int ARF_WIDTH = $clog2(ARF_SIZE),
    parameter int PRF_WIDTH = $clog2(PRF_SIZE),
    parameter int CNT_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_WAY-1:0]              commit_valid_i,
    input  logic [N_WAY*ARF_WIDTH-1:0]    commit_arn_i,
    input  logic [N_WAY*PRF_WIDTH-1:0]    commit_prn_i,
    output logic [N_WAY-1:0]              free_valid_o,
    output logic [N_WAY*PRF_WIDTH-1:0]    free_prn_o,
    output logic [CNT_WIDTH-1:0]          retired_cnt_o,
    output logic [ARF_SIZE*PRF_WIDTH-1:0] rrat_table_o
);

    localparam logic [ARF_WIDTH-1:0] ZERO_ARN = ARF_WIDTH'(ZERO_REG);

    logic [ARF_SIZE-1:0][PRF_WIDTH-1:0] table_q, table_d;
    logic [CNT_WIDTH-1:0]               retired_cnt_q, retired_cnt_d;
    logic [N_WAY-1:0][ARF_WIDTH-1:0]    arn;
    logic [N_WAY-1:0][PRF_WIDTH-1:0]    prn;
    logic [N_WAY-1:0]                   eff;

    assign arn = commit_arn_i;
    assign prn = commit_prn_i;

    always_comb begin
        eff = '0;
        for (int i = 0; i < N_WAY; i++) begin
            eff[i] = commit_valid_i[i] && (arn[i] != ZERO_ARN);
        end
    end

    // Ascending way order: the youngest same-ARN writer lands last and wins.
    always_comb begin
        table_d = table_q;
        for (int i = 0; i < N_WAY; i++) begin
            if (eff[i]) begin
                table_d[arn[i]] = prn[i];
            end
        end
        table_d[ZERO_REG] = PRF_WIDTH'(ZERO_REG);
    end

    always_comb begin
        retired_cnt_d = retired_cnt_q;
        for (int i = 0; i < N_WAY; i++) begin
            retired_cnt_d = retired_cnt_d + CNT_WIDTH'(commit_valid_i[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int a = 0; a < ARF_SIZE; a++) begin
                table_q[a] <= PRF_WIDTH'(a);
            end
            retired_cnt_q <= '0;
        end else begin
            table_q       <= table_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign rrat_table_o  = table_q;
    assign retired_cnt_o = retired_cnt_q;

`ifdef RRAT_FREE_OUT_EN
    logic [N_WAY-1:0]                free_valid_q, free_valid_d;
    logic [N_WAY-1:0][PRF_WIDTH-1:0] free_prn_q, free_prn_d;

    // Nearest older same-ARN way shadows the pre-update table entry.
    always_comb begin
        free_valid_d = eff;
        free_prn_d   = '0;
        for (int i = 0; i < N_WAY; i++) begin
            if (eff[i]) begin
                free_prn_d[i] = table_q[arn[i]];
                for (int j = 0; j < i; j++) begin
                    if (eff[j] && (arn[j] == arn[i])) begin
                        free_prn_d[i] = prn[j];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            free_valid_q <= '0;
            free_prn_q   <= '0;
        end else begin
            free_valid_q <= free_valid_d;
            free_prn_q   <= free_prn_d;
        end
    end

    assign free_valid_o = free_valid_q;
    assign free_prn_o   = free_prn_q;
`else
    assign free_valid_o = '0;
    assign free_prn_o   = '0;
`endif

endmodule

// File: doc/rrat_nway.md
# rrat_nway

Parametrised retirement register alias table (RRAT) for the R10K-style back end. It holds the committed architectural-to-physical register mapping and applies up to N_WAY in-order commits from the RoB each cycle, resolving same-group write-after-write conflicts. Every commit that supersedes a mapping reports the superseded PRN, so the free list can reclaim it. The full committed table is exported every cycle for front-end RAT recovery on a flush.

## Interface
- N_WAY, 3, commit ways per cycle; way 0 is oldest in program order.
- ARF_SIZE, 32, architectural registers.
- PRF_SIZE, 64, physical registers; must be >= ARF_SIZE.
- ZERO_REG, 31, hardwired-zero architectural register; writes to it are ignored.
- ARF_WIDTH, $clog2(ARF_SIZE), derived.
- PRF_WIDTH, $clog2(PRF_SIZE), derived.
- CNT_WIDTH, 32, width of the retired-instruction counter.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- commit_valid_i  in  N_WAY  per-way commit valid.
- commit_arn_i  in  N_WAY*ARF_WIDTH  destination ARN; way i is at bits [i*ARF_WIDTH +: ARF_WIDTH].
- commit_prn_i  in  N_WAY*PRF_WIDTH  destination PRN; packed the same way.
- free_valid_o  out  N_WAY  registered: way i released a PRN last cycle.
- free_prn_o  out  N_WAY*PRF_WIDTH  registered released PRNs.
- retired_cnt_o  out  CNT_WIDTH  registered count of valid commits since reset.
- rrat_table_o  out  ARF_SIZE*PRF_WIDTH  committed table; entry a is at bits [a*PRF_WIDTH +: PRF_WIDTH].

## Operation
- Reset (rst_n=0 at a clock edge):
  - table[a] = a for every a (identity mapping);
  - free_valid_o = 0 and free_prn_o = 0;
  - retired_cnt_o = 0.
- Reset overrides any commit presented in the same cycle; that commit is lost.
- A way is effective when commit_valid_i[i]=1 and commit_arn_i[i] != ZERO_REG.
- Superseded PRN for effective way i: the commit_prn of the nearest older effective way j<i with the same ARN; if there is none, the current table[arn].
- Table update: for each ARN, the youngest effective way writing it updates the table. Older same-ARN ways do not update the table, but still report their superseded PRN.
- Next-cycle free outputs: free_valid_o[i] = effective(i), free_prn_o[i] = superseded PRN of way i. For non-effective ways, free_prn_o[i] = 0.
- Each effective way releases exactly one PRN. No PRN is released twice within a group.
- retired_cnt_o increments by popcount(commit_valid_i), counting ZERO_REG commits too. It wraps modulo 2^CNT_WIDTH.
- There is no stall and no backpressure: the free list must accept N_WAY releases per cycle.
- table[ZERO_REG] stays at its reset value ZERO_REG permanently.

## Timing
- Table write latency is 1 cycle: commits at edge k are visible on rrat_table_o after edge k.
- rrat_table_o is driven directly from state, with no combinational path from the inputs.
- free_valid_o and free_prn_o are registered and valid in the cycle after the commit. They are held for one cycle only and are 0 when the next cycle has no effective commit.
- The superseded-PRN lookup reads the pre-update table, so there is no same-cycle bypass.
- retired_cnt_o updates in the cycle after the commit.

## Configuration
- RRAT_FREE_OUT_EN
  - Defined: free-release logic and registers are built as described above.
  - Undefined: the superseded-PRN logic is removed and free_valid_o and free_prn_o are tied to 0. The ports remain, so the interface is unchanged. Table and counter behaviour is identical in both builds.

## Test plan
All scenarios use N_WAY=3, ARF_SIZE=32, PRF_SIZE=64, ZERO_REG=31.
- Reset: hold rst_n=0 for 2 cycles, then release -> table[a]=a for all a, free_valid_o=0, retired_cnt_o=0.
- Single commit: way0 commits arn5->prn40 -> next cycle table[5]=40, free_valid_o=3'b001, free_prn_o[0]=5, retired_cnt_o=1.
- Full WAW group: all three ways commit arn7, prn 41, 42, 43 -> table[7]=43, free_prn_o = {42, 41, 7}, free_valid_o=3'b111.
- Zero register: way1 commits arn31->prn50 and way2 commits arn3->prn51 -> table[31]=31, table[3]=51, free_valid_o=3'b100, retired_cnt_o +2.
- Reset mid-stream: rst_n=0 in the same cycle as a commit arn5->prn44 -> table[5]=5 and free_valid_o=0 next cycle.
- Counter wrap with CNT_WIDTH=4: 6 cycles of 3 valid commits -> retired_cnt_o reads 3, 6, 9, 12, 15, 2.
